// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: steals cpu6502 bus cycles for round-robin DMA requesters via the CPU ready line.
// A grant is issued only once the CPU is parked on a read, since the 6502 ignores ready on writes.
module cpu_bus_arbiter #(
    parameter int NREQ      = 2,
    parameter int MAX_BURST = 4,
    parameter int MIN_CPU   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [15:0]          cpu_address,
    input  logic                 cpu_write,
    input  logic [7:0]           cpu_data_o,
    output logic                 cpu_ready,
    input  logic [NREQ-1:0]      dma_req,
    input  logic [16*NREQ-1:0]   dma_addr,
    input  logic [NREQ-1:0]      dma_we,
    input  logic [8*NREQ-1:0]    dma_wdata,
    output logic [NREQ-1:0]      dma_gnt,
    output logic [15:0]          mem_address,
    output logic                 mem_write,
    output logic [7:0]           mem_wdata,
    output logic                 bus_busy
);
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] STALL = 2'd1;
    localparam logic [1:0] GRANT = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            ready_q, ready_d, busy_q;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   rr_q, rr_d, win_q, win_d, pick;
    logic [7:0]      burst_q, burst_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [15:0]     addr_a [NREQ];
    logic [7:0]      wd_a [NREQ];
    logic            own;
    int              best, d;

    genvar g;
    for (g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_a[g] = dma_addr[16*g +: 16];
        assign wd_a[g]   = dma_wdata[8*g +: 8];
    end

    // win_q doubles as the owner register; a nonzero grant means the DMA owns the bus
    assign own         = |gnt_q;
    assign mem_address = own ? addr_a[win_q] : cpu_address;
    assign mem_wdata   = own ? wd_a[win_q] : cpu_data_o;
    assign mem_write   = own ? dma_we[win_q] & dma_req[win_q] : cpu_write;
    assign cpu_ready   = ready_q;
    assign dma_gnt     = gnt_q;
    assign bus_busy    = busy_q;

    always_comb begin
        pick = '0;
        best = NREQ;
        d    = 0;
        for (int i = 0; i < NREQ; i++) begin
            d = (i - int'(rr_q) + NREQ) % NREQ;
            if (dma_req[i] && d < best) begin
                best = d;
                pick = IW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        win_d   = win_q;
        burst_d = burst_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                cnt_d   = (cnt_q >= 4'(MIN_CPU)) ? cnt_q : cnt_q + 4'd1;
                // counting the current cycle keeps ready high for exactly MIN_CPU cycles
                if (|dma_req && ({1'b0, cnt_q} + 5'd1 >= 5'(MIN_CPU))) begin
                    state_d = STALL;
                    ready_d = 1'b0;
                    win_d   = pick;
                end
            end
            STALL: begin
                if (!dma_req[win_q]) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end else if (!cpu_write) begin
                    state_d        = GRANT;
                    gnt_d          = '0;
                    gnt_d[win_q]   = 1'b1;
                    burst_d        = 8'd0;
                end
            end
            GRANT: begin
                if (dma_req[win_q]) burst_d = burst_q + 8'd1;
                if (!dma_req[win_q] || ({1'b0, burst_q} + 9'd1 >= 9'(MAX_BURST))) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    gnt_d   = '0;
                    cnt_d   = 4'd0;
                    rr_d    = (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            gnt_q   <= '0;
            rr_q    <= '0;
            win_q   <= '0;
            burst_q <= 8'd0;
            cnt_q   <= 4'(MIN_CPU);
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            busy_q  <= state_d != IDLE;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            win_q   <= win_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb_cpu_bus_arbiter: directed checks of reset, bursts, write deferral, round robin and request drops.
module tb_cpu_bus_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_address;
    logic        cpu_write;
    logic [7:0]  cpu_data_o;
    logic [1:0]  dma_req, dma_we;
    logic [31:0] dma_addr;
    logic [15:0] dma_wdata;
    logic        ready4, mwr4, busy4, ready2, mwr2, busy2;
    logic [1:0]  gnt4, gnt2;
    logic [15:0] maddr4, maddr2;
    logic [7:0]  mwd4, mwd2;
    int          total = 0;
    int          bad = 0;
    logic        er, ew, eb;
    logic [1:0]  eg;
    logic [15:0] ea;
    logic [7:0]  ed;
    logic [23:0] gs;
    logic [11:0] rs;

    cpu_bus_arbiter #(.NREQ(2), .MAX_BURST(4), .MIN_CPU(1)) u4 (
        .clk(clk), .reset(reset), .cpu_address(cpu_address), .cpu_write(cpu_write),
        .cpu_data_o(cpu_data_o), .cpu_ready(ready4), .dma_req(dma_req), .dma_addr(dma_addr),
        .dma_we(dma_we), .dma_wdata(dma_wdata), .dma_gnt(gnt4), .mem_address(maddr4),
        .mem_write(mwr4), .mem_wdata(mwd4), .bus_busy(busy4)
    );

    cpu_bus_arbiter #(.NREQ(2), .MAX_BURST(2), .MIN_CPU(1)) u2 (
        .clk(clk), .reset(reset), .cpu_address(cpu_address), .cpu_write(cpu_write),
        .cpu_data_o(cpu_data_o), .cpu_ready(ready2), .dma_req(dma_req), .dma_addr(dma_addr),
        .dma_we(dma_we), .dma_wdata(dma_wdata), .dma_gnt(gnt2), .mem_address(maddr2),
        .mem_write(mwr2), .mem_wdata(mwd2), .bus_busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        cpu_address = 16'h1234;
        cpu_write   = 1'b0;
        cpu_data_o  = 8'h11;
        dma_req     = 2'b00;
        dma_we      = 2'b00;
        dma_addr    = {16'hE000, 16'hD000};
        dma_wdata   = {8'h5A, 8'hA5};
    endtask

    task automatic rst_all;
        idle_in;
        @(posedge clk);
        #2 reset = 1'b1;
        #4 reset = 1'b0;
    endtask

    task automatic test_reset;
        rst_all;
        total += 3;
        if (ready4 !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", ready4); end
        if (gnt4 !== 2'b00) begin bad++; $display("FAIL rst_gnt got=%b exp=00", gnt4); end
        if (busy4 !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy4); end
        for (int k = 0; k < 4; k++) begin
            cyc;
            dma_req = 2'b01;
        end
        #2;
        total++;
        if (gnt4 !== 2'b01) begin bad++; $display("FAIL rst_pregrant got=%b exp=01", gnt4); end
        reset = 1'b1;
        #1;
        total += 4;
        if (ready4 !== 1'b1) begin bad++; $display("FAIL rst_async_ready got=%b exp=1", ready4); end
        if (gnt4 !== 2'b00) begin bad++; $display("FAIL rst_async_gnt got=%b exp=00", gnt4); end
        if (busy4 !== 1'b0) begin bad++; $display("FAIL rst_async_busy got=%b exp=0", busy4); end
        if (maddr4 !== 16'h1234) begin bad++; $display("FAIL rst_async_addr got=%h exp=1234", maddr4); end
        dma_req = 2'b00;
        #2 reset = 1'b0;
        cyc;
        #2;
        total += 2;
        if (maddr4 !== 16'h1234) begin bad++; $display("FAIL rst_after_addr got=%h exp=1234", maddr4); end
        if (ready4 !== 1'b1) begin bad++; $display("FAIL rst_after_ready got=%b exp=1", ready4); end
    endtask

    task automatic test_single_burst;
        rst_all;
        for (int k = 0; k < 7; k++) begin
            cyc;
            dma_req = (k <= 5) ? 2'b01 : 2'b00;
            #2;
            er = !(k >= 1 && k <= 5);
            eb = (k >= 1 && k <= 5);
            eg = (k >= 2 && k <= 5) ? 2'b01 : 2'b00;
            ea = (k >= 2 && k <= 5) ? 16'hD000 : 16'h1234;
            total += 4;
            if (ready4 !== er) begin bad++; $display("FAIL burst_ready k=%0d got=%b exp=%b", k, ready4, er); end
            if (busy4 !== eb) begin bad++; $display("FAIL burst_busy k=%0d got=%b exp=%b", k, busy4, eb); end
            if (gnt4 !== eg) begin bad++; $display("FAIL burst_gnt k=%0d got=%b exp=%b", k, gnt4, eg); end
            if (maddr4 !== ea) begin bad++; $display("FAIL burst_addr k=%0d got=%h exp=%h", k, maddr4, ea); end
        end
    endtask

    task automatic test_write_deferral;
        rst_all;
        for (int k = 0; k < 10; k++) begin
            cyc;
            dma_req     = (k <= 8) ? 2'b01 : 2'b00;
            dma_we      = 2'b01;
            cpu_write   = (k >= 1 && k <= 3);
            cpu_address = (k == 1) ? 16'h01FF : (k == 2) ? 16'h01FE : (k == 3) ? 16'h01FD : 16'h1234;
            #2;
            er = !(k >= 1 && k <= 8);
            ew = (k >= 1 && k <= 3) || (k >= 5 && k <= 8);
            eg = (k >= 5 && k <= 8) ? 2'b01 : 2'b00;
            ea = (k >= 5 && k <= 8) ? 16'hD000 : (k == 1) ? 16'h01FF : (k == 2) ? 16'h01FE :
                 (k == 3) ? 16'h01FD : 16'h1234;
            ed = (k >= 5 && k <= 8) ? 8'hA5 : 8'h11;
            total += 5;
            if (ready4 !== er) begin bad++; $display("FAIL defer_ready k=%0d got=%b exp=%b", k, ready4, er); end
            if (mwr4 !== ew) begin bad++; $display("FAIL defer_mwrite k=%0d got=%b exp=%b", k, mwr4, ew); end
            if (gnt4 !== eg) begin bad++; $display("FAIL defer_gnt k=%0d got=%b exp=%b", k, gnt4, eg); end
            if (maddr4 !== ea) begin bad++; $display("FAIL defer_addr k=%0d got=%h exp=%h", k, maddr4, ea); end
            if (mwd4 !== ed) begin bad++; $display("FAIL defer_wdata k=%0d got=%h exp=%h", k, mwd4, ed); end
        end
        idle_in;
    endtask

    task automatic test_round_robin;
        rst_all;
        gs = 24'h50A050;
        rs = 12'h111;
        for (int k = 0; k < 12; k++) begin
            cyc;
            dma_req = 2'b11;
            #2;
            eg = gs[2*k +: 2];
            er = rs[k];
            ea = (eg == 2'b01) ? 16'hD000 : (eg == 2'b10) ? 16'hE000 : 16'h1234;
            total += 3;
            if (gnt2 !== eg) begin bad++; $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, gnt2, eg); end
            if (ready2 !== er) begin bad++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, ready2, er); end
            if (maddr2 !== ea) begin bad++; $display("FAIL rr_addr k=%0d got=%h exp=%h", k, maddr2, ea); end
        end
        idle_in;
    endtask

    task automatic test_early_drop;
        rst_all;
        for (int k = 0; k < 9; k++) begin
            cyc;
            dma_req = (k <= 2) ? 2'b10 : (k >= 4 && k <= 6) ? 2'b11 : 2'b00;
            dma_we  = 2'b10;
            #2;
            eg = (k == 2 || k == 3) ? 2'b10 : (k == 6 || k == 7) ? 2'b01 : 2'b00;
            er = (k == 0 || k == 4 || k == 8);
            ew = (k == 2);
            total += 3;
            if (gnt4 !== eg) begin bad++; $display("FAIL drop_gnt k=%0d got=%b exp=%b", k, gnt4, eg); end
            if (ready4 !== er) begin bad++; $display("FAIL drop_ready k=%0d got=%b exp=%b", k, ready4, er); end
            if (mwr4 !== ew) begin bad++; $display("FAIL drop_mwrite k=%0d got=%b exp=%b", k, mwr4, ew); end
        end
        idle_in;
    endtask

    task automatic test_stall_drop;
        rst_all;
        for (int k = 0; k < 6; k++) begin
            cyc;
            dma_req     = (k == 0) ? 2'b01 : 2'b00;
            dma_we      = 2'b01;
            cpu_write   = (k == 1);
            cpu_address = (k == 1) ? 16'h01FF : 16'h1234;
            #2;
            er = (k != 1);
            eb = (k == 1);
            ew = (k == 1);
            ea = (k == 1) ? 16'h01FF : 16'h1234;
            total += 5;
            if (ready4 !== er) begin bad++; $display("FAIL sdrop_ready k=%0d got=%b exp=%b", k, ready4, er); end
            if (busy4 !== eb) begin bad++; $display("FAIL sdrop_busy k=%0d got=%b exp=%b", k, busy4, eb); end
            if (gnt4 !== 2'b00) begin bad++; $display("FAIL sdrop_gnt k=%0d got=%b exp=00", k, gnt4); end
            if (mwr4 !== ew) begin bad++; $display("FAIL sdrop_mwrite k=%0d got=%b exp=%b", k, mwr4, ew); end
            if (maddr4 !== ea) begin bad++; $display("FAIL sdrop_addr k=%0d got=%h exp=%h", k, maddr4, ea); end
        end
        idle_in;
    endtask

    initial begin
        idle_in;
        test_reset;
        test_single_burst;
        test_write_deferral;
        test_round_robin;
        test_early_drop;
        test_stall_drop;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
